// File: rtl/verin_log_pkg.sv
// Shared types and helpers for the verin sample logger: FSM states,
// the constant byte-enable and the circular-pointer advance.
package verin_log_pkg;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    // Advance a circular offset, returning to 0 after depth-1.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/verin_log_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; rdata shows the head
// whenever empty is low. Flush wins over a same-cycle push or pop.
module verin_log_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rd_q];

    always_comb begin
        do_push = push & ~full & ~flush;
        do_pop  = pop & ~empty & ~flush;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/verin_sample_logger.sv
// Buffers actuator samples and drains them as single-beat Avalon-MM writes
// into a circular RAM region, tracking write pointer, wrap and drop count.
module verin_sample_logger
    import verin_log_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int BASE_WORD   = 0,
    parameter int DEPTH_WORDS = 5000,
    parameter int FIFO_DEPTH  = 8,
    parameter int OVF_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [31:0]       sample_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic [OVF_W-1:0]  overflow_cnt,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wrapped_q, wrapped_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic              clr_pend_q, clr_pend_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    logic [31:0]       fifo_rdata;
    logic              accept, drop, beat_done;

    verin_log_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (sample_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        wr_ptr_d   = wr_ptr_q;
        wrapped_d  = wrapped_q;
        ovf_d      = ovf_q;
        clr_pend_d = clr_pend_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        // Full is sampled before any pop this cycle, so a full FIFO drops.
        accept    = sample_valid & enable & ~clear;
        fifo_push = accept & ~fifo_full;
        drop      = accept & fifo_full;
        beat_done = write_q & ~avm_waitrequest;

        if (drop && ovf_q != '1) ovf_d = ovf_q + OVF_W'(1);

        case (state_q)
            IDLE: begin
                if (clear) begin
                    fifo_flush = 1'b1;
                    wr_ptr_d   = '0;
                    wrapped_d  = 1'b0;
                    ovf_d      = '0;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rdata;
                    addr_d   = ADDR_W'(BASE_WORD) + wr_ptr_q;
                    write_d  = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (clear) clr_pend_d = 1'b1;
                if (beat_done) begin
                    write_d = 1'b0;
                    state_d = IDLE;
                    // A pending clear retires with this beat and leaves wr_ptr at 0.
                    if (clr_pend_q || clear) begin
                        fifo_flush = 1'b1;
                        wr_ptr_d   = '0;
                        wrapped_d  = 1'b0;
                        ovf_d      = '0;
                        clr_pend_d = 1'b0;
                    end else begin
                        wr_ptr_d = ADDR_W'(ptr_next(int'(wr_ptr_q), DEPTH_WORDS));
                        if (wr_ptr_q == ADDR_W'(DEPTH_WORDS - 1)) wrapped_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            wr_ptr_q   <= '0;
            wrapped_q  <= 1'b0;
            ovf_q      <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_q    <= write_d;
            wr_ptr_q   <= wr_ptr_d;
            wrapped_q  <= wrapped_d;
            ovf_q      <= ovf_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_write      = write_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = BYTEEN_ALL;
    assign wr_ptr         = wr_ptr_q;
    assign wrapped        = wrapped_q;
    assign overflow_cnt   = ovf_q;
    assign busy           = ~fifo_empty | write_q;

endmodule

// File: tb/tb_verin_sample_logger.sv
// Directed bench for verin_sample_logger with a 4-word region so wrap is reachable.
module tb_verin_sample_logger;

    localparam int ADDR_W = 13;
    localparam int OVF_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              clear;
    logic              sample_valid;
    logic [31:0]       sample_data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wrapped;
    logic [OVF_W-1:0]  overflow_cnt;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    int beat_addr[$];
    int beat_data[$];

    verin_sample_logger #(
        .ADDR_W      (ADDR_W),
        .BASE_WORD   (0),
        .DEPTH_WORDS (4),
        .FIFO_DEPTH  (8),
        .OVF_W       (OVF_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .clear           (clear),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .wr_ptr          (wr_ptr),
        .wrapped         (wrapped),
        .overflow_cnt    (overflow_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Accepted beats, sampled mid-cycle while request and stall are stable.
    always @(negedge clk) begin
        if (!reset && avm_write && !avm_waitrequest) begin
            beat_addr.push_back(int'(avm_address));
            beat_data.push_back(int'(avm_writedata));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_write(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (avm_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [31:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; clear = 1'b0; sample_valid = 1'b0;
        sample_data = '0; avm_waitrequest = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({avm_write, avm_address, avm_writedata, wr_ptr, wrapped, overflow_cnt, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got w=%0b a=%0h d=%0h p=%0h wr=%0b o=%0h b=%0b expected all 0",
                     avm_write, avm_address, avm_writedata, wr_ptr, wrapped, overflow_cnt, busy);
        end
        n_tests++;
        if (avm_byteenable !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_byteenable: got %0h expected f", avm_byteenable);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        int exp_d[3] = '{32'hA1, 32'hA2, 32'hA3};
        beat_addr.delete(); beat_data.delete();
        sample_valid = 1'b1; sample_data = 32'hA1; step();
        sample_data = 32'hA2; step();
        n_tests++;
        if (avm_write !== 1'b1 || avm_address !== 13'd0 || avm_writedata !== 32'hA1) begin
            n_fail++;
            $display("FAIL basic_latency: got w=%0b a=%0h d=%0h expected w=1 a=0 d=a1",
                     avm_write, avm_address, avm_writedata);
        end
        sample_data = 32'hA3; step();
        sample_valid = 1'b0;
        wait_idle(50, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL basic_drain: busy still %0b expected 0", busy); end
        n_tests++;
        if (beat_addr.size() != 3) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d beats expected 3", beat_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (beat_addr[i] != i || beat_data[i] != exp_d[i]) begin
                    n_fail++;
                    $display("FAIL basic_beat%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                             i, beat_addr[i], beat_data[i], i, exp_d[i]);
                end
            end
        end
        n_tests++;
        if (wr_ptr !== 13'd3 || overflow_cnt !== '0 || wrapped !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: got p=%0d o=%0d wr=%0b expected p=3 o=0 wr=0",
                     wr_ptr, overflow_cnt, wrapped);
        end
    endtask

    task automatic test_stall();
        bit ok;
        beat_addr.delete(); beat_data.delete();
        avm_waitrequest = 1'b1;
        send(32'hB1);
        wait_write(10, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL stall_start: avm_write got 0 expected 1"); end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (avm_write !== 1'b1 || avm_address !== 13'd0 || avm_writedata !== 32'hB1
                || beat_addr.size() != 0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got w=%0b a=%0h d=%0h n=%0d expected w=1 a=0 d=b1 n=0",
                         i, avm_write, avm_address, avm_writedata, beat_addr.size());
            end
            step();
        end
        avm_waitrequest = 1'b0;
        wait_idle(20, ok);
        n_tests++;
        if (!ok || beat_addr.size() != 1 || beat_addr[0] != 0 || beat_data[0] != 32'hB1
            || wr_ptr !== 13'd1) begin
            n_fail++;
            $display("FAIL stall_result: got ok=%0b n=%0d p=%0d expected ok=1 n=1 a=0 d=b1 p=1",
                     ok, beat_addr.size(), wr_ptr);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        beat_addr.delete(); beat_data.delete();
        avm_waitrequest = 1'b1;
        sample_valid = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            sample_data = 32'h100 + i;
            step();
        end
        sample_valid = 1'b0;
        n_tests++;
        if (overflow_cnt !== 16'd3 || busy !== 1'b1 || avm_writedata !== 32'h101
            || beat_addr.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_count: got o=%0d b=%0b d=%0h n=%0d expected o=3 b=1 d=101 n=0",
                     overflow_cnt, busy, avm_writedata, beat_addr.size());
        end
        avm_waitrequest = 1'b0;
        wait_idle(100, ok);
        n_tests++;
        if (!ok || beat_addr.size() != 9) begin
            n_fail++;
            $display("FAIL ovf_drain: got ok=%0b n=%0d expected ok=1 n=9", ok, beat_addr.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_tests++;
                if (beat_addr[i] != i % 4 || beat_data[i] != 32'h101 + i) begin
                    n_fail++;
                    $display("FAIL ovf_beat%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                             i, beat_addr[i], beat_data[i], i % 4, 32'h101 + i);
                end
            end
        end
        n_tests++;
        if (wr_ptr !== 13'd1 || wrapped !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_ptr: got p=%0d wr=%0b expected p=1 wr=1", wr_ptr, wrapped);
        end
    endtask

    task automatic test_clear_stall();
        bit ok;
        beat_addr.delete(); beat_data.delete();
        avm_waitrequest = 1'b1;
        send(32'hC1);
        wait_write(10, ok);
        n_tests++;
        if (!ok || avm_address !== 13'd1 || avm_writedata !== 32'hC1) begin
            n_fail++;
            $display("FAIL clrs_start: got ok=%0b a=%0h d=%0h expected ok=1 a=1 d=c1",
                     ok, avm_address, avm_writedata);
        end
        clear = 1'b1; sample_valid = 1'b1; sample_data = 32'hC2; step();
        clear = 1'b0; sample_data = 32'hC3; step();
        sample_valid = 1'b0; step();
        n_tests++;
        if (avm_write !== 1'b1 || avm_address !== 13'd1 || avm_writedata !== 32'hC1) begin
            n_fail++;
            $display("FAIL clrs_hold: got w=%0b a=%0h d=%0h expected w=1 a=1 d=c1",
                     avm_write, avm_address, avm_writedata);
        end
        avm_waitrequest = 1'b0;
        wait_idle(20, ok);
        repeat (4) step();
        n_tests++;
        if (!ok || beat_addr.size() != 1 || beat_addr[0] != 1 || beat_data[0] != 32'hC1) begin
            n_fail++;
            $display("FAIL clrs_beat: got ok=%0b n=%0d expected ok=1 n=1 a=1 d=c1",
                     ok, beat_addr.size());
        end
        n_tests++;
        if (wr_ptr !== '0 || wrapped !== 1'b0 || overflow_cnt !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clrs_status: got p=%0d wr=%0b o=%0d b=%0b expected all 0",
                     wr_ptr, wrapped, overflow_cnt, busy);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int exp_a[6] = '{0, 1, 2, 3, 0, 1};
        beat_addr.delete(); beat_data.delete();
        avm_waitrequest = 1'b0;
        sample_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            sample_data = i;
            step();
        end
        sample_valid = 1'b0;
        wait_idle(60, ok);
        n_tests++;
        if (!ok || beat_addr.size() != 6) begin
            n_fail++;
            $display("FAIL wrap_drain: got ok=%0b n=%0d expected ok=1 n=6", ok, beat_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (beat_addr[i] != exp_a[i] || beat_data[i] != i + 1) begin
                    n_fail++;
                    $display("FAIL wrap_beat%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                             i, beat_addr[i], beat_data[i], exp_a[i], i + 1);
                end
            end
        end
        n_tests++;
        if (wrapped !== 1'b1 || wr_ptr !== 13'd2) begin
            n_fail++;
            $display("FAIL wrap_status: got wr=%0b p=%0d expected wr=1 p=2", wrapped, wr_ptr);
        end
    endtask

    task automatic test_clear_idle();
        beat_addr.delete(); beat_data.delete();
        clear = 1'b1; sample_valid = 1'b1; sample_data = 32'hD1; step();
        clear = 1'b0; sample_valid = 1'b0;
        n_tests++;
        if (wr_ptr !== '0 || wrapped !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clri_status: got p=%0d wr=%0b b=%0b expected 0 0 0", wr_ptr, wrapped, busy);
        end
        repeat (4) step();
        n_tests++;
        if (beat_addr.size() != 0 || avm_write !== 1'b0) begin
            n_fail++;
            $display("FAIL clri_discard: got n=%0d w=%0b expected n=0 w=0", beat_addr.size(), avm_write);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        avm_waitrequest = 1'b0;
        send(32'hE1);
        wait_idle(20, ok);
        avm_waitrequest = 1'b1;
        send(32'hE2);
        wait_write(10, ok);
        n_tests++;
        if (!ok || wr_ptr !== 13'd1) begin
            n_fail++;
            $display("FAIL areset_setup: got ok=%0b p=%0d expected ok=1 p=1", ok, wr_ptr);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({avm_write, wr_ptr, wrapped, overflow_cnt, busy} !== '0 || avm_byteenable !== 4'hF) begin
            n_fail++;
            $display("FAIL areset_outputs: got w=%0b p=%0d wr=%0b o=%0d b=%0b be=%0h expected 0s be=f",
                     avm_write, wr_ptr, wrapped, overflow_cnt, busy, avm_byteenable);
        end
        step();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        reset = 1'b1; step(); reset = 1'b0; step();
        test_stall();
        reset = 1'b1; step(); reset = 1'b0; step();
        test_overflow();
        test_clear_stall();
        test_wrap();
        test_clear_idle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
